// File: rtl/sensor_input_conditioner.sv
// sensor_input_conditioner
// Synchronises and debounces the raw field-sensor switches (low/mid/high water level,
// earth humidity, air humidity, low temperature) and reports settled transitions.
//
// Ports:
//   clock         system clock, rising edge
//   reset_n       asynchronous active-low reset
//   sample_tick   debounce qualifier; counters only advance while high
//   raw_levels    asynchronous switch inputs
//   clean_levels  debounced, registered levels
//   level_changed one-cycle pulse when any clean bit updates
//   change_mask   bits that updated this cycle (zero when level_changed is low)
//
// Bit order: 0 low_water, 1 mid_water, 2 high_water, 3 earth_humidity,
//            4 air_humidity, 5 low_temperature.

module sensor_input_conditioner #(
    parameter int unsigned       WIDTH        = 6,
    parameter int unsigned       SYNC_STAGES  = 2,
    parameter int unsigned       STABLE_TICKS = 16,
    parameter logic [WIDTH-1:0]  RESET_VALUE  = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             sample_tick,
    input  logic [WIDTH-1:0] raw_levels,
    output logic [WIDTH-1:0] clean_levels,
    output logic             level_changed,
    output logic [WIDTH-1:0] change_mask
);

    localparam int unsigned CntW = $clog2(STABLE_TICKS);
    localparam logic [CntW-1:0] CntMax = CntW'(STABLE_TICKS - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_lvl;
    logic [WIDTH-1:0] pending;

    logic [CntW-1:0]  cnt_q [WIDTH];
    logic [CntW-1:0]  cnt_d [WIDTH];
    logic [WIDTH-1:0] clean_q, clean_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             changed_q, changed_d;

    // Synchroniser chain; stage 0 is the only flop that sees the raw pins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= RESET_VALUE;
            end
        end else begin
            sync_q[0] <= raw_levels;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // Per-bit state is implied by the registered levels: a bit is PENDING exactly while
    // its synchronised level differs from its clean level, STABLE otherwise. The edge on
    // which sync first differs is therefore the STABLE->PENDING edge and the counter
    // (held at 0 in STABLE) does not advance on it.
    assign pending = sync_lvl ^ clean_q;

    always_comb begin
        clean_d = clean_q;
        mask_d  = '0;
        cnt_d   = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (!pending[i]) begin
                // Stable, or a glitch returned to the clean value: restart qualification.
                cnt_d[i] = '0;
            end else if (sample_tick) begin
                if (cnt_q[i] == CntMax) begin
                    clean_d[i] = sync_lvl[i];
                    mask_d[i]  = 1'b1;
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
        changed_d = |mask_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clean_q   <= RESET_VALUE;
            mask_q    <= '0;
            changed_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            clean_q   <= clean_d;
            mask_q    <= mask_d;
            changed_q <= changed_d;
            cnt_q     <= cnt_d;
        end
    end

    assign clean_levels  = clean_q;
    assign level_changed = changed_q;
    assign change_mask   = mask_q;

endmodule
